gcd_job_sequencer: RTL
======================

// Module: gcd_job_sequencer
// PURPOSE
//  Upstream front end for the GCD core (controller + datapath). Accepts (A,B) jobs on a valid/ready
//  input, drives the core's start and shared data_in bus in the core's A-then-B load order, and
//  waits for done. Captures the result and returns it on a valid/ready output. Clears the core
//  between jobs, because the core parks in its done state until cleared.
// PARAMETERS
//  WIDTH          16    operand/result width in bits
//  TIMEOUT_CYCLES 1024  max WAIT cycles before abort (used only with GCD_SEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  in_valid     in   1      job request
//  in_ready     out  1      job accepted when in_valid & in_ready
//  in_a         in   WIDTH  operand A
//  in_b         in   WIDTH  operand B
//  core_start   out  1      start pulse to GCD controller
//  core_data    out  WIDTH  data_in bus to GCD datapath
//  core_clr     out  1      sync active-high clear of GCD controller/datapath
//  core_done    in   1      GCD controller done
//  core_result  in   WIDTH  GCD datapath result (valid while core_done=1)
//  out_valid    out  1      response valid; held until out_ready
//  out_ready    in   1      response consumed when out_valid & out_ready
//  out_gcd      out  WIDTH  gcd(A,B); stable while out_valid
//  out_err      out  1      job aborted by timeout (constant 0 without GCD_SEQ_TIMEOUT_EN)
//  busy         out  1      high in every state except IDLE
// BEHAVIOUR
//  - One clock domain (clk). Reset is asynchronous, active-low (rst_n).
//  - All outputs are registered. Reset values:
//    - state=IDLE, in_ready=1, core_start=0, core_data=0, out_valid=0, out_gcd=0, out_err=0, busy=0.
//    - core_clr resets to 1 and drops to 0 on the first clk edge after rst_n deasserts.
//  - FSM, one cycle per state unless noted:
//    - IDLE: in_ready=1. On accept, latch A and B.
//      - If A==0 or B==0: go to RESP with out_gcd = A|B. This bypass covers gcd(x,0)=x and
//        gcd(0,0)=0, and the core is not launched. Otherwise go to LAUNCH.
//    - LAUNCH: core_start=1, core_data=A.
//    - FEED_A: core_start=0, core_data=A. This is the cycle the controller asserts enA.
//    - FEED_B: core_data=B. This is the cycle the controller asserts enB.
//    - WAIT: core_data=B. Hold until core_done=1, then capture core_result into out_gcd and go to CLEAR.
//    - CLEAR: core_clr=1 for exactly one cycle, then go to RESP.
//    - RESP: out_valid=1. Hold until out_ready=1, then go to IDLE.
//  - in_ready=0 in every state except IDLE; at most one job is in flight.
//  - Accept-to-out_valid latency: 5 + (core compute cycles). Bypass latency: 1 cycle.
//  - core_done arriving in any state other than WAIT is ignored.
//  - out_ready asserted while out_valid=0 has no effect.
//  - Back-to-back: after the RESP handshake, IDLE accepts a new job in the next cycle.
//  - Reset mid-job: the async reset returns the FSM to IDLE and drops any partial result.
//    core_clr=1 during reset also clears the core.
// CONFIGURATION
//  - GCD_SEQ_TIMEOUT_EN defined:
//    - A counter runs in WAIT.
//    - If core_done has not arrived after TIMEOUT_CYCLES cycles in WAIT, go to CLEAR with
//      out_gcd=0 and out_err=1.
//    - out_err is held with out_valid and cleared on the RESP handshake.
//  - GCD_SEQ_TIMEOUT_EN undefined: no counter; WAIT is unbounded; out_err is tied to 0.
// STRUCTURE
//  - Package gcd_seq_pkg:
//    - state enum {IDLE, LAUNCH, FEED_A, FEED_B, WAIT, CLEAR, RESP}, 3-bit encoding;
//    - GCD_WIDTH_DEFAULT=16;
//    - TIMEOUT_DEFAULT=1024.
//  - Sub-module gcd_seq_watchdog: cycle counter with clear and enable inputs and an expire output,
//    instantiated only under GCD_SEQ_TIMEOUT_EN. Everything else is inline.
// TESTING
//  1. Job A=48, B=18 against the real GCD core -> core_data is 48 in FEED_A and 18 in FEED_B;
//     out_gcd=6; core_clr pulses exactly one cycle.
//  2. A=0, B=35 -> out_valid on the next cycle with out_gcd=35; core_start never asserted.
//     Repeat with A=0, B=0 -> out_gcd=0.
//  3. out_ready held low 10 cycles after out_valid -> out_gcd stays 6 and in_ready stays 0;
//     releasing out_ready -> in_ready=1 on the next cycle.
//  4. Back-to-back jobs (13,13), (17,5), (1024,256) with out_ready tied high -> 13, 1, 256 in order;
//     no job dropped.
//  5. rst_n pulsed low while in WAIT -> all outputs at reset values asynchronously; core_clr=1;
//     the next job (9,6) returns 3.
//  6. GCD_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=8 and core_done tied low -> exactly 8 WAIT cycles,
//     then CLEAR, then RESP with out_err=1 and out_gcd=0.

Source files
------------

// File: rtl/gcd_seq_pkg.sv
// Shared types and defaults for the GCD job sequencer.
package gcd_seq_pkg;

    localparam int GCD_WIDTH_DEFAULT = 16;
    localparam int TIMEOUT_DEFAULT   = 1024;

    // Sequencer states; LAUNCH..FEED_B follow the core's start/A/B load order.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        FEED_A = 3'd2,
        FEED_B = 3'd3,
        WAIT   = 3'd4,
        CLEAR  = 3'd5,
        RESP   = 3'd6
    } state_t;

endpackage

// File: rtl/gcd_seq_watchdog.sv
// Cycle counter that expires after LIMIT enabled cycles. Used by
// gcd_job_sequencer only when GCD_SEQ_TIMEOUT_EN is defined.
module gcd_seq_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // Count enabled cycles; clear has priority and the count parks at expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expire) begin
            count <= count + 1'b1;
        end
    end

    // count holds the cycles already spent, so the LIMIT-th cycle is when count==LIMIT-1.
    assign expire = en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/gcd_job_sequencer.sv
// Front end for the GCD core: accepts (A,B) jobs, feeds the core in its
// start / A / B order, waits for done, clears the core and returns the result.
// Optional feature macro: GCD_SEQ_TIMEOUT_EN adds a WAIT-state watchdog that
// aborts a job with out_err=1 after TIMEOUT_CYCLES cycles.
module gcd_job_sequencer
    import gcd_seq_pkg::*;
#(
    parameter int WIDTH          = GCD_WIDTH_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             core_start,
    output logic [WIDTH-1:0] core_data,
    output logic             core_clr,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic             out_err,
    output logic             busy
);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_q, b_q, a_next, b_next;
    logic [WIDTH-1:0] gcd_next, core_data_next;
    logic             err_q, err_next;
    logic             wd_expire;

`ifdef GCD_SEQ_TIMEOUT_EN
    gcd_seq_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state != WAIT),
        .en     (state == WAIT),
        .expire (wd_expire)
    );
    assign out_err = err_q;
`else
    // Without the watchdog the limit is not needed; this keeps the parameter referenced.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign wd_expire      = 1'b0;
    assign out_err        = 1'b0;
`endif

    // Next-state, operand latch and result capture.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        a_next     = a_q;
        b_next     = b_q;
        gcd_next   = out_gcd;
        err_next   = err_q;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    a_next = in_a;
                    b_next = in_b;
                    if (in_a == '0 || in_b == '0) begin
                        // gcd(x,0)=x and gcd(0,0)=0 without launching the core.
                        gcd_next   = in_a | in_b;
                        err_next   = 1'b0;
                        state_next = RESP;
                    end else begin
                        state_next = LAUNCH;
                    end
                end
            end
            LAUNCH: state_next = FEED_A;
            FEED_A: state_next = FEED_B;
            FEED_B: state_next = WAIT;
            WAIT: begin
                if (core_done) begin
                    gcd_next   = core_result;
                    state_next = CLEAR;
                end else if (wd_expire) begin
                    gcd_next   = '0;
                    err_next   = 1'b1;
                    state_next = CLEAR;
                end
            end
            CLEAR: state_next = RESP;
            RESP: begin
                if (out_ready) begin
                    err_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Data bus value for the upcoming state so core_data can be registered.
    always_comb begin
        core_data_next = core_data;
        case (state_next)
            LAUNCH, FEED_A: core_data_next = a_next;
            FEED_B, WAIT:   core_data_next = b_next;
            default:        core_data_next = core_data;
        endcase
    end

    // State and registered outputs, all decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            in_ready   <= 1'b1;
            core_start <= 1'b0;
            core_data  <= '0;
            core_clr   <= 1'b1;
            out_valid  <= 1'b0;
            out_gcd    <= '0;
            err_q      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_next;
            a_q        <= a_next;
            b_q        <= b_next;
            in_ready   <= (state_next == IDLE);
            core_start <= (state_next == LAUNCH);
            core_data  <= core_data_next;
            core_clr   <= (state_next == CLEAR);
            out_valid  <= (state_next == RESP);
            out_gcd    <= gcd_next;
            err_q      <= err_next;
            busy       <= (state_next != IDLE);
        end
    end

endmodule
